buf_reader: RTL

Consumer-side controller for the team's FIFO `buffer` block. It drives the buffer's level-sensitive read request (`re`) and `r_ack` handshake, pulls `WORDS` consecutive `DATA_L`-bit entries, and packs them into one wide word. The packed word is presented downstream on a valid/ready interface. It sits between a `buffer` instance and a 64-bit datapath consumer, for example an instruction/operand fetch stage.

---
 rtl/buf_reader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/buf_reader.sv
// buf_reader: drains WORDS entries from a FIFO buffer over the re/r_ack handshake and
// presents them packed on a valid/ready port. Define BUF_READER_TIMEOUT_EN for the r_ack watchdog.
module buf_reader #(
  parameter int BUF_ID  = 0,
  parameter int DATA_L  = 16,
  parameter int WORDS   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    avail,
  input  logic                    r_ack,
  input  logic [DATA_L-1:0]       din,
  output logic                    re,
  output logic [DATA_L*WORDS-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              word_cnt,
  output logic                    err_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      re_q, re_d;
  logic                      out_valid_q, out_valid_d;
  logic [DATA_L*WORDS-1:0]   out_data_q, out_data_d;
  // One bit wider than the port so WORDS=8 can be reached before wrapping.
  logic [3:0]                cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic                      tmo_hit_s;
  logic                      tmo_inc_s;
  logic                      timeout_s;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      re_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      re_q        <= re_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic for the read handshake and packet assembly
  always_comb begin
    state_d     = state_q;
    re_d        = re_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    tmo_inc_s   = 1'b0;
    timeout_s   = 1'b0;
    case (state_q)
      IDLE: begin
        // A stale acknowledge must drain before a new request is raised.
        if (avail && !r_ack) begin
          re_d    = 1'b1;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (r_ack) begin
          out_data_d[cnt_q[2:0]*DATA_L +: DATA_L] = din;
          re_d    = 1'b0;
          state_d = DROP;
        end else if (tmo_hit_s) begin
          timeout_s = 1'b1;
        end else begin
          tmo_inc_s = 1'b1;
        end
      end
      DROP: begin
        if (!r_ack) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == 4'(WORDS)) begin
            out_valid_d = 1'b1;
            state_d     = OUT;
          end else begin
            state_d = IDLE;
          end
        end else if (tmo_hit_s) begin
          timeout_s = 1'b1;
        end else begin
          tmo_inc_s = 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = 4'd0;
          state_d     = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (timeout_s) begin
      err_d   = 1'b1;
      re_d    = 1'b0;
      cnt_d   = 4'd0;
      state_d = IDLE;
    end else begin
      err_d = err_q;
    end
  end

`ifdef BUF_READER_TIMEOUT_EN
  logic [3:0] tmo_q, tmo_d;

  assign tmo_hit_s = (tmo_q == 4'(TIMEOUT - 1));

  // Wait counter restarts whenever the FSM is not idling in REQ/DROP
  always_comb begin
    if (tmo_inc_s) begin
      tmo_d = tmo_q + 4'd1;
    end else begin
      tmo_d = 4'd0;
    end
  end

  // Wait counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= 4'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

`ifndef SYNTHESIS
  // Simulation notice when the watchdog fires
  always_ff @(posedge clk) begin
    if (!rst && timeout_s) begin
      $display("buf_reader[%0d]: r_ack timeout, partial packet of %0d dropped", BUF_ID, cnt_q);
    end
  end
`endif
`else
  logic unused_cfg_s;

  assign tmo_hit_s    = 1'b0;
  assign unused_cfg_s = ^{tmo_inc_s, 32'(BUF_ID), 32'(TIMEOUT)};
`endif

  assign re          = re_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign word_cnt    = cnt_q[2:0];
  assign err_timeout = err_q;

endmodule
